// File: rtl/chreq_pkg.sv
// rtl/chreq_pkg.sv - shared types, default header layout and sizing helpers for the channel requester
package chreq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_HDR = 3'd1,
        ST_LATCH  = 3'd2,
        ST_ARB    = 3'd3,
        ST_REQ    = 3'd4,
        ST_WAIT   = 3'd5,
        ST_PRE_RD = 3'd6,
        ST_SEND   = 3'd7
    } state_t;

    // Default position/width of the byte-length field in the header word
    localparam int DEF_LEN_LSB   = 7;
    localparam int DEF_LEN_W     = 10;
    localparam int DEF_BLK_BYTES = 64;
    localparam int DEF_HDR_BYTES = 4;

    // Payload words needed to carry len bytes on a dwidth-bit bus
    function automatic int unsigned words_for(input int unsigned len, input int unsigned dwidth);
        return (len + (dwidth / 8) - 1) / (dwidth / 8);
    endfunction

    // RAM blocks needed for header plus payload; 32-bit math keeps the sum untruncated
    function automatic int unsigned blocks_for(input int unsigned len, input int unsigned hdr_bytes,
                                               input int unsigned blk_bytes);
        return (len + hdr_bytes + blk_bytes - 1) / blk_bytes;
    endfunction

endpackage

// File: rtl/rot_prior_enc.sv
// rtl/rot_prior_enc.sv - rotating priority encoder: first set bit at or after start, modulo N
module rot_prior_enc #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Walk offsets from farthest to nearest so the nearest set bit is the last to write index
    always_comb begin
        int j;
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (vec[j]) begin
                valid = 1'b1;
                index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/channel_req_rr.sv
// rtl/channel_req_rr.sv - per-channel ingress requester; CHREQ_TIMEOUT_EN adds a WAIT timeout
module channel_req_rr
    import chreq_pkg::*;
#(
    parameter int PORTNUM     = 16,
    parameter int DWIDTH      = 32,
    parameter int RAMWIDTH    = 10,
    parameter int LEN_LSB     = DEF_LEN_LSB,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int BLK_BYTES   = DEF_BLK_BYTES,
    parameter int HDR_BYTES   = DEF_HDR_BYTES,
    parameter int PORT_ID     = 0,
    parameter int RR_EN       = 1,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DWIDTH-1:0]   i_data,
    input  logic                i_empty,
    output logic                o_rd_en,
    input  logic [PORTNUM-1:0]  i_ready,
    input  logic [RAMWIDTH-1:0] i_ramspace [PORTNUM],
    output logic [PORTNUM-1:0]  o_req,
    input  logic [PORTNUM-1:0]  i_resp,
    input  logic [PORTNUM-1:0]  i_nresp,
    output logic [DWIDTH-1:0]   o_data,
    output logic                o_data_vld,
    output logic                o_sop,
    output logic                o_eop,
    output logic                o_busy
);

    localparam int IW = $clog2(PORTNUM);
    localparam int CW = ((RAMWIDTH > LEN_W) ? RAMWIDTH : LEN_W) + 1;
    localparam int PW = LEN_W + 1;

    // Elaboration-time guard against configurations the datapath cannot honour
    if (PORTNUM < 2 || PORT_ID >= PORTNUM || (DWIDTH % 8) != 0 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("channel_req_rr: illegal parameter combination");
    end

    state_t              state, state_nx;
    logic [DWIDTH-1:0]   hdr;
    logic [PW-1:0]       p_words;
    logic [CW-1:0]       b_need;
    logic [PW-1:0]       cnt;
    logic [PORTNUM-1:0]  excl;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       sel;
    logic [LEN_W-1:0]    hdr_len;
    logic [PORTNUM-1:0]  elig;
    logic [PORTNUM-1:0]  cand;
    logic                excl_clr;
    logic                cand_vld;
    logic [IW-1:0]       cand_idx;
    logic                resp_sel;
    logic                nresp_sel;
    logic                timeout;

    assign hdr_len   = i_data[LEN_LSB +: LEN_W];
    assign resp_sel  = i_resp[sel];
    assign nresp_sel = i_nresp[sel];
    assign o_busy    = (state != ST_IDLE);

`ifdef CHREQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    assign timeout = (state == ST_WAIT) && (to_cnt == TW'(TIMEOUT_CYC - 1));

    // WAIT-cycle counter, restarted every time WAIT is entered
    always_ff @(posedge i_clk) begin
        if (i_rst || state != ST_WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Eligible ports; exclusions are dropped once they would hide every eligible port
    always_comb begin
        elig = '0;
        for (int p = 0; p < PORTNUM; p++) begin
            elig[p] = i_ready[p] && (CW'(i_ramspace[p]) >= b_need);
        end
        excl_clr = (elig != '0) && ((elig & ~excl) == '0);
        cand     = excl_clr ? elig : (elig & ~excl);
    end

    rot_prior_enc #(
        .N  (PORTNUM),
        .IW (IW)
    ) u_enc (
        .vec   (cand),
        .start (ptr),
        .valid (cand_vld),
        .index (cand_idx)
    );

    // Next-state and Moore strobes
    always_comb begin
        state_nx = state;
        o_rd_en  = 1'b0;
        o_req    = '0;
        case (state)
            ST_IDLE: begin
                if (!i_empty) begin
                    state_nx = ST_RD_HDR;
                end
            end
            ST_RD_HDR: begin
                o_rd_en  = 1'b1;
                state_nx = ST_LATCH;
            end
            ST_LATCH: begin
                state_nx = ST_ARB;
            end
            ST_ARB: begin
                if (cand_vld) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                o_req    = PORTNUM'(1) << sel;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_sel) begin
                    state_nx = ST_PRE_RD;
                end else if (nresp_sel || timeout) begin
                    state_nx = ST_ARB;
                end
            end
            ST_PRE_RD: begin
                o_rd_en  = (p_words != '0);
                state_nx = ST_SEND;
            end
            ST_SEND: begin
                // Pop word cnt+2 so it lands on o_data two cycles later
                o_rd_en = ((cnt + PW'(1)) < p_words);
                if (cnt == p_words) begin
                    state_nx = i_empty ? ST_IDLE : ST_RD_HDR;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, packet bookkeeping and registered output stream
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            hdr        <= '0;
            p_words    <= '0;
            b_need     <= '0;
            cnt        <= '0;
            excl       <= '0;
            ptr        <= IW'(PORT_ID);
            sel        <= '0;
            o_data     <= '0;
            o_data_vld <= 1'b0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
        end else begin
            state      <= state_nx;
            o_data_vld <= 1'b0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    excl <= '0;
                end
                ST_LATCH: begin
                    hdr     <= i_data;
                    p_words <= PW'(words_for(32'(hdr_len), DWIDTH));
                    b_need  <= CW'(blocks_for(32'(hdr_len), HDR_BYTES, BLK_BYTES));
                end
                ST_ARB: begin
                    if (excl_clr) begin
                        excl <= '0;
                    end
                    if (cand_vld) begin
                        sel <= cand_idx;
                    end
                end
                ST_WAIT: begin
                    if (resp_sel) begin
                        if (RR_EN != 0) begin
                            ptr <= (sel == IW'(PORTNUM - 1)) ? '0 : sel + IW'(1);
                        end
                    end else if (nresp_sel || timeout) begin
                        excl[sel] <= 1'b1;
                    end
                end
                ST_PRE_RD: begin
                    o_data     <= hdr;
                    o_data_vld <= 1'b1;
                    o_sop      <= 1'b1;
                    o_eop      <= (p_words == '0);
                    cnt        <= '0;
                end
                ST_SEND: begin
                    if (cnt != p_words) begin
                        o_data     <= i_data;
                        o_data_vld <= 1'b1;
                        o_eop      <= ((cnt + PW'(1)) == p_words);
                        cnt        <= cnt + PW'(1);
                    end else begin
                        excl <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
